// File: rtl/instr_encoder.sv
// Encodes instruction requests into 32-bit MIPS words and streams them into
// instruction memory at consecutive word addresses, with optional branch delay-slot NOPs.
module instr_encoder #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DEPTH      = 1024,
    parameter bit          DELAY_SLOT = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_kind_i,
    input  logic [4:0]        req_rs_i,
    input  logic [4:0]        req_rt_i,
    input  logic [4:0]        req_rd_i,
    input  logic [15:0]       req_imm_i,
    input  logic [25:0]       req_target_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o
);

    typedef enum logic [1:0] {StIdle, StEmit, StEmitNop} state_e;

    localparam logic [ADDR_W:0] DepthC = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] OneC   = (ADDR_W + 1)'(1);

    state_e            state_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              err_q;
    logic              slot_q;
    logic              full;
    logic              kind_legal;
    logic              is_branch;
    logic [31:0]       enc_word;

    assign count_inc   = count_q + OneC;
    assign full        = (count_q == DepthC);
    assign kind_legal  = (req_kind_i <= 4'd8);
    assign is_branch   = (req_kind_i == 4'd2) || (req_kind_i == 4'd7) || (req_kind_i == 4'd8);
    assign req_ready_o = (state_q == StIdle) && !full;

    always_comb begin
        enc_word = '0;
        case (req_kind_i)
            4'd0:    enc_word = {6'b000000, req_rs_i, req_rt_i, req_rd_i, 5'b00000, 6'b100001};
            4'd1:    enc_word = {6'b000000, req_rs_i, req_rt_i, req_rd_i, 5'b00000, 6'b100011};
            4'd2:    enc_word = {6'b000000, req_rs_i, 15'b0, 6'b001000};
            4'd3:    enc_word = {6'b001101, req_rs_i, req_rt_i, req_imm_i};
            4'd4:    enc_word = {6'b001111, 5'b00000, req_rt_i, req_imm_i};
            4'd5:    enc_word = {6'b100011, req_rs_i, req_rt_i, req_imm_i};
            4'd6:    enc_word = {6'b101011, req_rs_i, req_rt_i, req_imm_i};
            4'd7:    enc_word = {6'b000100, req_rs_i, req_rt_i, req_imm_i};
            4'd8:    enc_word = {6'b000011, req_target_i};
            default: enc_word = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            slot_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= StIdle;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            slot_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i && req_ready_o) begin
                        if (kind_legal) begin
                            state_q <= StEmit;
                            we_q    <= 1'b1;
                            addr_q  <= count_q[ADDR_W-1:0];
                            wdata_q <= enc_word;
                            slot_q  <= DELAY_SLOT && is_branch;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StEmit: begin
                    count_q <= count_inc;
                    if (slot_q && (count_inc != DepthC)) begin
                        state_q <= StEmitNop;
                        addr_q  <= count_inc[ADDR_W-1:0];
                        wdata_q <= '0;
                    end else begin
                        // A delay slot that would not fit in memory is dropped and flagged.
                        state_q <= StIdle;
                        we_q    <= 1'b0;
                        if (slot_q) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StEmitNop: begin
                    count_q <= count_inc;
                    state_q <= StIdle;
                    we_q    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign im_we_o    = we_q;
    assign im_addr_o  = addr_q;
    assign im_wdata_o = wdata_q;
    assign count_o    = count_q;
    assign full_o     = full;
    assign err_o      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: three instances (plain, delay-slot, 4-word memory) checked
// against a request-level model of the expected memory writes.
module tb_instr_encoder;

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          inst;
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear [3];
    logic        valid [3];
    logic        ready [3];
    logic [3:0]  kind  [3];
    logic [4:0]  rs    [3];
    logic [4:0]  rt    [3];
    logic [4:0]  rd    [3];
    logic [15:0] imm   [3];
    logic [25:0] tgt   [3];
    logic        we    [3];
    logic [9:0]  addr  [3];
    logic [31:0] wdata [3];
    logic [10:0] count [3];
    logic        full  [3];
    logic        err   [3];

    int n_checks = 0;
    int n_fail   = 0;
    int max_addr2 = -1;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  m_cnt   [3] = '{0, 0, 0};
    bit  m_err   [3] = '{0, 0, 0};
    int  m_depth [3] = '{1024, 1024, 4};
    bit  m_ds    [3] = '{0, 1, 1};
    vec_t tbl[9];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        instr_encoder #(
            .ADDR_W    (10),
            .DEPTH     (g == 2 ? 4 : 1024),
            .DELAY_SLOT(g != 0)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .clear_i     (clear[g]),
            .req_valid_i (valid[g]),
            .req_ready_o (ready[g]),
            .req_kind_i  (kind[g]),
            .req_rs_i    (rs[g]),
            .req_rt_i    (rt[g]),
            .req_rd_i    (rd[g]),
            .req_imm_i   (imm[g]),
            .req_target_i(tgt[g]),
            .im_we_o     (we[g]),
            .im_addr_o   (addr[g]),
            .im_wdata_o  (wdata[g]),
            .count_o     (count[g]),
            .full_o      (full[g]),
            .err_o       (err[g])
        );
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (we[i] === 1'b1) begin
                got_q.push_back('{i, int'(addr[i]), wdata[i]});
                if (i == 2 && int'(addr[i]) > max_addr2) max_addr2 = int'(addr[i]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Word built from the field layout of each instruction format.
    function automatic logic [31:0] model_enc(vec_t r);
        int unsigned opc [9] = '{0, 0, 0, 13, 15, 35, 43, 4, 3};
        int unsigned k   = r.kind;
        int unsigned frs = r.rs;
        int unsigned frt = r.rt;
        int unsigned frd = r.rd;
        int unsigned fim = r.imm;
        int unsigned ftg = r.tgt;
        int unsigned w;
        if (k == 0 || k == 1)
            w = frs * 2097152 + frt * 65536 + frd * 2048 + (k == 0 ? 33 : 35);
        else if (k == 2)
            w = frs * 2097152 + 8;
        else if (k == 8)
            w = opc[k] * 67108864 + ftg;
        else
            w = opc[k] * 67108864 + (k == 4 ? 0 : frs * 2097152) + frt * 65536 + fim;
        return w;
    endfunction

    function automatic void model_accept(int i, vec_t r);
        if (r.kind > 8) begin
            m_err[i] = 1;
            return;
        end
        exp_q.push_back('{i, m_cnt[i], model_enc(r)});
        m_cnt[i]++;
        if (m_ds[i] && (r.kind == 2 || r.kind == 7 || r.kind == 8)) begin
            if (m_cnt[i] < m_depth[i]) begin
                exp_q.push_back('{i, m_cnt[i], 32'h0});
                m_cnt[i]++;
            end else begin
                m_err[i] = 1;
            end
        end
    endfunction

    function automatic logic [63:0] pk(wr_t w);
        return {8'(w.inst), 24'(w.addr), w.data};
    endfunction

    // Returns one tick after the accepting edge, i.e. inside the write cycle.
    task automatic send(int i, vec_t r, int max_wait, output bit acc);
        int n = 0;
        acc = 0;
        kind[i] = r.kind; rs[i] = r.rs; rt[i] = r.rt; rd[i] = r.rd;
        imm[i] = r.imm; tgt[i] = r.tgt; valid[i] = 1'b1;
        while (!acc && n < max_wait) begin
            @(negedge clk);
            if (ready[i] === 1'b1) begin
                @(posedge clk);
                #1;
                acc = 1;
            end else begin
                n++;
            end
        end
        valid[i] = 1'b0;
        if (acc) model_accept(i, r);
    endtask

    task automatic req(int i, vec_t r);
        bit acc;
        send(i, r, 20, acc);
        check($sformatf("accept inst%0d", i), 64'(acc), 64'd1);
    endtask

    task automatic do_clear(int i);
        clear[i] = 1'b1;
        @(posedge clk);
        #1;
        clear[i] = 1'b0;
        m_cnt[i] = 0;
        m_err[i] = 0;
    endtask

    task automatic verify(string name, int i);
        wr_t g, e;
        repeat (4) @(posedge clk);
        #1;
        check({name, " n_writes"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({name, " write"}, pk(g), pk(e));
        end
        got_q.delete();
        exp_q.delete();
        check({name, " count"}, 64'(count[i]), 64'(m_cnt[i]));
        check({name, " err"}, 64'(err[i]), 64'(m_err[i]));
        check({name, " full"}, 64'(full[i]), 64'(m_cnt[i] == m_depth[i]));
    endtask

    function automatic vec_t mk(int k, int s, int t, int d, int im, int tg);
        vec_t v;
        v.kind = 4'(k); v.rs = 5'(s); v.rt = 5'(t); v.rd = 5'(d);
        v.imm = 16'(im); v.tgt = 26'(tg); v.exp = '0;
        return v;
    endfunction

    initial begin
        vec_t v;
        bit   acc;

        tbl[0] = '{4'd0, 5'd1,  5'd2, 5'd3, 16'h0000, 26'h0, 32'h00221821};
        tbl[1] = '{4'd3, 5'd0,  5'd5, 5'd0, 16'h1234, 26'h0, 32'h34051234};
        tbl[2] = '{4'd4, 5'd0,  5'd1, 5'd0, 16'hFFFF, 26'h0, 32'h3C01FFFF};
        tbl[3] = '{4'd6, 5'd0,  5'd2, 5'd0, 16'h0004, 26'h0, 32'hAC020004};
        tbl[4] = '{4'd2, 5'd31, 5'd0, 5'd0, 16'h0000, 26'h0, 32'h03E00008};
        tbl[5] = '{4'd1, 5'd4,  5'd5, 5'd6, 16'h0000, 26'h0, 32'h00853023};
        tbl[6] = '{4'd5, 5'd29, 5'd8, 5'd0, 16'h0010, 26'h0, 32'h8FA80010};
        tbl[7] = '{4'd7, 5'd1,  5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h1022FFFF};
        tbl[8] = '{4'd8, 5'd0,  5'd0, 5'd0, 16'h0000, 26'h000C00, 32'h0C000C00};

        for (int i = 0; i < 3; i++) begin
            clear[i] = 0; valid[i] = 0; kind[i] = 0; rs[i] = 0; rt[i] = 0;
            rd[i] = 0; imm[i] = 0; tgt[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            check("reset outs", {we[i], addr[i], wdata[i], count[i], full[i], err[i]}, 64'd0);
            check("reset ready", 64'(ready[i]), 64'd1);
        end

        // First write: ready drops for the write cycle only.
        req(0, tbl[0]);
        check("first ready", 64'(ready[0]), 64'd0);
        check("first we", 64'(we[0]), 64'd1);
        check("first addr", 64'(addr[0]), 64'd0);
        check("first wdata", 64'(wdata[0]), 64'h00221821);
        @(posedge clk);
        #1;
        check("first we after", 64'(we[0]), 64'd0);
        check("first count", 64'(count[0]), 64'd1);
        check("first ready after", 64'(ready[0]), 64'd1);
        verify("first", 0);

        do_clear(0);
        for (int k = 0; k < 9; k++) begin
            req(0, tbl[k]);
            check($sformatf("tbl%0d we", k), 64'(we[0]), 64'd1);
            check($sformatf("tbl%0d addr", k), 64'(addr[0]), 64'(k));
            check($sformatf("tbl%0d wdata", k), 64'(wdata[0]), 64'(tbl[k].exp));
        end
        verify("table", 0);

        // Delay slot: beq then jal each followed by a NOP.
        req(1, tbl[7]);
        req(1, tbl[8]);
        verify("delay_slot", 1);
        check("delay_slot count", 64'(count[1]), 64'd4);

        // Illegal kind: consumed, no write, sticky err.
        do_clear(0);
        send(0, mk(12, 1, 2, 3, 0, 0), 20, acc);
        check("illegal accept", 64'(acc), 64'd1);
        check("illegal ready", 64'(ready[0]), 64'd1);
        check("illegal we", 64'(we[0]), 64'd0);
        check("illegal err", 64'(err[0]), 64'd1);
        req(0, tbl[1]);
        verify("illegal", 0);
        do_clear(0);
        check("clear err", 64'(err[0]), 64'd0);
        check("clear count", 64'(count[0]), 64'd0);
        req(0, tbl[2]);
        check("after clear addr", 64'(addr[0]), 64'd0);
        verify("after clear", 0);

        // Clear wins over a same-cycle accept.
        kind[0] = 4'd0; rs[0] = 5'd1; valid[0] = 1'b1; clear[0] = 1'b1;
        @(posedge clk);
        #1;
        valid[0] = 1'b0; clear[0] = 1'b0;
        m_cnt[0] = 0; m_err[0] = 0;
        check("clear prio we", 64'(we[0]), 64'd0);
        verify("clear prio", 0);

        // Four-word memory: fifth request must never be taken.
        for (int k = 0; k < 4; k++) req(2, mk(0, k, k + 1, k + 2, 0, 0));
        send(2, mk(0, 7, 7, 7, 0, 0), 10, acc);
        check("full 5th accept", 64'(acc), 64'd0);
        check("full flag", 64'(full[2]), 64'd1);
        check("full ready", 64'(ready[2]), 64'd0);
        check("full max addr", 64'(max_addr2), 64'd3);
        verify("full", 2);

        // Branch landing on the last word: NOP dropped, err set.
        do_clear(2);
        for (int k = 0; k < 3; k++) req(2, mk(1, k, k, k, 0, 0));
        req(2, tbl[7]);
        verify("full nop drop", 2);
        check("full nop max addr", 64'(max_addr2), 64'd3);

        for (int i = 0; i < 2; i++) begin
            do_clear(i);
            repeat (60) begin
                v = mk($urandom_range(0, 10), $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 65535), $urandom & 26'h3FFFFFF);
                req(i, v);
            end
            verify($sformatf("random inst%0d", i), i);
        end

        // Async reset in the middle of a write cycle.
        do_clear(0);
        req(0, tbl[0]);
        req(0, tbl[1]);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst we", 64'(we[0]), 64'd0);
        check("rst count", 64'(count[0]), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_err[i] = 0;
        end
        req(0, tbl[3]);
        check("rst next addr", 64'(addr[0]), 64'd0);
        verify("after reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
